seq_chunk_addsub: RTL and testbench
===================================

Name: seq_chunk_addsub

Overview:
- Multi-cycle, parametrised add/subtract unit.
- Captures two WIDTH-bit operands through a valid/ready handshake.
- Computes the result CHUNK bits per cycle, LSB chunk first, with the inter-chunk carry held in a flop.
- Presents result, carry-out and signed overflow through a valid/ready output handshake.
- Area-lean arithmetic block for the datapath, e.g. a wide/ADC-style add where a single-cycle WIDTH-bit adder is not wanted.

Parameters:
- WIDTH, 32, operand/result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 8, bits processed per cycle; 1 <= CHUNK <= WIDTH.
- NCHUNK (local), WIDTH/CHUNK, number of compute cycles per operation.

Ports:
- clk, input, 1, clock; all state updates on posedge.
- rst, input, 1, synchronous active-low reset (rst=0 resets on the next posedge).
- in_valid, input, 1, operand request valid.
- in_ready, output, 1, unit can accept an operation.
- in_a, input, WIDTH, operand A.
- in_b, input, WIDTH, operand B.
- in_sub, input, 1, 0 = A+B+cin; 1 = A+~B+cin (plain subtract uses cin=1).
- in_cin, input, 1, carry-in.
- out_valid, output, 1, result valid.
- out_ready, input, 1, consumer accepts result.
- out_result, output, WIDTH, sum/difference.
- out_cout, output, 1, carry-out of MSB (for subtract: 1 = no borrow).
- out_ovf, output, 1, two's-complement signed overflow.

Behaviour:
- FSM states and outputs:
  - IDLE: in_ready=1, out_valid=0.
  - CALC: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Reset (rst=0 at a posedge):
  - state=IDLE, chunk counter=0, carry flop=0, operand registers=0.
  - out_result=0, out_cout=0, out_ovf=0, out_valid=0.
  - in_ready is forced 0 while rst=0.
  - Reset mid-CALC or mid-DONE aborts the operation; no partial result is ever presented.
- Accept: posedge with in_valid && in_ready (state IDLE):
  - Register A.
  - Register B_eff = in_sub ? ~in_b : in_b.
  - Carry flop <= in_cin, counter <= 0, state <= CALC.
  - in_valid with in_ready=0 is ignored; the unit does not sample inputs outside IDLE.
- CALC, each posedge:
  - {carry, result chunk[cnt]} <= A chunk[cnt] + B_eff chunk[cnt] + carry, computed at CHUNK+1 bits.
  - cnt increments.
  - On the posedge where cnt == NCHUNK-1:
    - out_cout <= chunk carry-out.
    - out_ovf <= (A[WIDTH-1] == B_eff[WIDTH-1]) && (final result[WIDTH-1] != A[WIDTH-1]).
    - state <= DONE.
- Latency: acceptance at edge k; out_valid is high from edge k+NCHUNK. With defaults NCHUNK=4; with CHUNK=WIDTH, latency is 1.
- DONE:
  - out_result, out_cout and out_ovf stay stable while out_valid && !out_ready.
  - Posedge with out_ready=1: state <= IDLE and out_valid <= 0. in_ready is 1 the following cycle.
  - No overlap of output completion and new acceptance: throughput is one operation per NCHUNK+2 cycles minimum.
- Arithmetic is modular 2^WIDTH. out_result equals (A + B_eff + cin) mod 2^WIDTH exactly as a single-cycle adder would produce.
- Counter width: max(1, $clog2(NCHUNK)); it never exceeds NCHUNK-1.
- out_* registers change only on reset or on the final CALC edge.

Test Plan:
- Defaults, in_a=0x000000FF, in_b=0x00000001, in_sub=0, in_cin=0 -> out_result=0x00000100, cout=0, ovf=0; out_valid rises exactly 4 cycles after the accept edge.
- in_a=0xFFFFFFFF, in_b=0x00000001, add, cin=0 -> result=0x00000000, cout=1, ovf=0 (carry ripples through all 4 chunks); in_a=0x7FFFFFFF, in_b=1 -> result=0x80000000, cout=0, ovf=1.
- in_a=0x7FFFFFFF, in_b=0xFFFFFFFF, in_sub=1, cin=1 -> result=0x80000000, cout=0, ovf=1; in_a=5, in_b=3, sub, cin=1 -> result=2, cout=1, ovf=0.
- Backpressure:
  - Hold out_ready=0 for 3 cycles after out_valid -> outputs unchanged, in_ready=0, a second in_valid is ignored.
  - Raise out_ready -> out_valid=0 next cycle, in_ready=1.
  - The following accepted op (0x10+0x20) yields 0x30.
- Reset mid-operation: assert rst=0 one cycle after acceptance (during CALC, cnt=1) -> next cycle out_valid=0, in_ready=0 while rst low, all out_* equal 0. After release, in_ready=1 and a fresh op 0x1234+0x1111 yields 0x2345 after 4 cycles.
- Parameter sweep WIDTH=16, CHUNK=16 and WIDTH=16, CHUNK=4 -> 0xFFFF+0x0001 gives result 0x0000, cout=1, with latency 1 and 4 respectively; randomized ops compared against a reference model.

Source files
------------

// File: rtl/seq_chunk_addsub.sv
// seq_chunk_addsub: multi-cycle add/subtract that processes CHUNK bits per
// cycle, LSB chunk first, and holds the inter-chunk carry in a flop.
//
// Ports:
//   clk        - clock, all state updates on posedge
//   rst        - synchronous active-low reset
//   in_valid   - operand request valid
//   in_ready   - unit can accept an operation (IDLE and not in reset)
//   in_a/in_b  - WIDTH-bit operands
//   in_sub     - 0: A+B+cin, 1: A+~B+cin
//   in_cin     - carry-in
//   out_valid  - result valid (DONE state)
//   out_ready  - consumer accepts result
//   out_result - WIDTH-bit sum/difference
//   out_cout   - carry-out of MSB (subtract: 1 = no borrow)
//   out_ovf    - two's-complement signed overflow
module seq_chunk_addsub #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CNTW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned SUMW   = CHUNK + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [CNTW-1:0]  cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] res_q;
  logic             cout_q;
  logic             ovf_q;

  logic [31:0]      shamt_c;
  logic [CHUNK-1:0] a_chunk_c;
  logic [CHUNK-1:0] b_chunk_c;
  logic [SUMW-1:0]  sum_c;
  logic [WIDTH-1:0] res_full_c;
  logic             last_c;
  logic             ovf_c;

  // Current chunk slice, chunk adder and the partially assembled result.
  // acc_q holds zeros above the current chunk, so OR-ing in is enough.
  always_comb begin
    shamt_c    = 32'(cnt_q) * CHUNK;
    a_chunk_c  = CHUNK'(a_q >> shamt_c);
    b_chunk_c  = CHUNK'(b_q >> shamt_c);
    sum_c      = SUMW'(a_chunk_c) + SUMW'(b_chunk_c) + SUMW'(carry_q);
    res_full_c = acc_q | (WIDTH'(sum_c[CHUNK-1:0]) << shamt_c);
    last_c     = (cnt_q == CNTW'(NCHUNK - 1));
    ovf_c      = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                 (res_full_c[WIDTH-1] != a_q[WIDTH-1]);
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_sub ? ~in_b : in_b;
            carry_q <= in_cin;
            cnt_q   <= '0;
            acc_q   <= '0;
            state_q <= CALC;
          end
        end
        CALC: begin
          acc_q   <= res_full_c;
          carry_q <= sum_c[CHUNK];
          if (last_c) begin
            res_q   <= res_full_c;
            cout_q  <= sum_c[CHUNK];
            ovf_q   <= ovf_c;
            cnt_q   <= '0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CNTW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // in_ready is gated by reset so nothing is offered while rst is low.
  assign in_ready   = rst && (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_result = res_q;
  assign out_cout   = cout_q;
  assign out_ovf    = ovf_q;

endmodule

// File: tb/tb_seq_chunk_addsub.sv
// Testbench for seq_chunk_addsub: default 32/8 instance plus 16/16 and 16/4
// instances sharing one stimulus set.
module tb_seq_chunk_addsub;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_sub, in_cin;
  logic        out_valid, out_ready, out_cout, out_ovf;
  logic [31:0] in_a, in_b, out_result;

  logic        s_valid, s_sub, s_cin, s_ready;
  logic [15:0] s_a, s_b;
  logic        r1_in_ready, r1_valid, r1_cout, r1_ovf;
  logic        r2_in_ready, r2_valid, r2_cout, r2_ovf;
  logic [15:0] r1_result, r2_result;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_chunk_addsub #(.WIDTH(32), .CHUNK(8)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_cout(out_cout), .out_ovf(out_ovf)
  );

  seq_chunk_addsub #(.WIDTH(16), .CHUNK(16)) dut1 (
    .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(r1_in_ready),
    .in_a(s_a), .in_b(s_b), .in_sub(s_sub), .in_cin(s_cin),
    .out_valid(r1_valid), .out_ready(s_ready), .out_result(r1_result),
    .out_cout(r1_cout), .out_ovf(r1_ovf)
  );

  seq_chunk_addsub #(.WIDTH(16), .CHUNK(4)) dut2 (
    .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(r2_in_ready),
    .in_a(s_a), .in_b(s_b), .in_sub(s_sub), .in_cin(s_cin),
    .out_valid(r2_valid), .out_ready(s_ready), .out_result(r2_result),
    .out_cout(r2_cout), .out_ovf(r2_ovf)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        cin;
    logic [31:0] res;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: {ovf, cout, result}
  function automatic logic [33:0] model32(input logic [31:0] a, input logic [31:0] b,
                                          input logic sub, input logic cin);
    logic [31:0] be;
    logic [32:0] s;
    be = sub ? ~b : b;
    s  = {1'b0, a} + {1'b0, be} + 33'(cin);
    return {((a[31] == be[31]) && (s[31] != a[31])), s};
  endfunction

  function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b,
                                          input logic sub, input logic cin);
    logic [15:0] be;
    logic [16:0] s;
    be = sub ? ~b : b;
    s  = {1'b0, a} + {1'b0, be} + 17'(cin);
    return {((a[15] == be[15]) && (s[15] != a[15])), s};
  endfunction

  // One full operation on dut0; lat counts cycles from accept edge to out_valid.
  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic sub,
                      input logic cin, output logic [31:0] res, output logic cout,
                      output logic ovf, output int lat);
    @(negedge clk);
    in_a = a; in_b = b; in_sub = sub; in_cin = cin; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    res = out_result; cout = out_cout; ovf = out_ovf;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // One operation on both 16-bit instances in parallel.
  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic sub,
                      input logic cin, output logic [16:0] o1, output logic [16:0] o2,
                      output int lat1, output int lat2);
    int n;
    @(negedge clk);
    s_a = a; s_b = b; s_sub = sub; s_cin = cin; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    n = 0; lat1 = -1; lat2 = -1; o1 = '0; o2 = '0;
    while (n < 20) begin
      if (r1_valid && lat1 < 0) begin lat1 = n; o1 = {r1_cout, r1_result}; end
      if (r2_valid && lat2 < 0) begin lat2 = n; o2 = {r2_cout, r2_result}; end
      if (lat1 >= 0 && lat2 >= 0) break;
      @(negedge clk);
      n++;
    end
    s_ready = 1'b1;
    @(negedge clk);
    s_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] res;
    logic        cout, ovf;
    int          lat, lat1, lat2;
    logic [33:0] m32;
    logic [17:0] m16;
    logic [16:0] o1, o2;
    logic [31:0] ra, rb;
    logic        rs, rc;

    vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[3] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h80000000, 1'b0, 1'b1};
    vecs[4] = '{32'h00000005, 32'h00000003, 1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0};
    vecs[5] = '{32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    vecs[6] = '{32'h00000000, 32'h00000001, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[7] = '{32'h12345678, 32'h11111111, 1'b0, 1'b1, 32'h2345678A, 1'b0, 1'b0};
    vecs[8] = '{32'h00FF00FF, 32'h00010001, 1'b0, 1'b0, 32'h01000100, 1'b0, 1'b0};

    rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_cin = 1'b0;
    out_ready = 1'b0;
    s_valid = 1'b0; s_a = '0; s_b = '0; s_sub = 1'b0; s_cin = 1'b0; s_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_result", 64'(out_result), 64'(0));
    chk("rst_cout_ovf", 64'({out_cout, out_ovf}), 64'(0));
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));
    chk("post_rst_in_ready_16", 64'({r1_in_ready, r2_in_ready}), 64'(3));

    // Directed table
    for (int i = 0; i < 9; i++) begin
      op32(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, res, cout, ovf, lat);
      chk($sformatf("v%0d_result", i), 64'(res), 64'(vecs[i].res));
      chk($sformatf("v%0d_cout", i), 64'(cout), 64'(vecs[i].cout));
      chk($sformatf("v%0d_ovf", i), 64'(ovf), 64'(vecs[i].ovf));
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(4));
    end

    // Random ops against the reference model
    for (int i = 0; i < 6; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom); rc = 1'($urandom);
      m32 = model32(ra, rb, rs, rc);
      op32(ra, rb, rs, rc, res, cout, ovf, lat);
      chk($sformatf("rnd%0d_32", i), 64'({ovf, cout, res}), 64'(m32));
    end

    // Backpressure: result must hold and new requests be ignored
    @(negedge clk);
    in_a = 32'hAAAA0000; in_b = 32'h00005555; in_sub = 1'b0; in_cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_a = 32'h00000001; in_b = 32'h00000001;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_latency", 64'(lat), 64'(4));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold_valid%0d", i), 64'(out_valid), 64'(1));
      chk($sformatf("bp_hold_ready%0d", i), 64'(in_ready), 64'(0));
      chk($sformatf("bp_hold_result%0d", i), 64'(out_result), 64'(32'hAAAA5555));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release_valid", 64'(out_valid), 64'(0));
    chk("bp_release_ready", 64'(in_ready), 64'(1));
    repeat (5) @(negedge clk);
    chk("bp_ignored_req", 64'(out_valid), 64'(0));
    op32(32'h10, 32'h20, 1'b0, 1'b0, res, cout, ovf, lat);
    chk("bp_next_result", 64'(res), 64'(32'h30));

    // Reset during CALC (cnt=1) aborts the operation
    @(negedge clk);
    in_a = 32'h55555555; in_b = 32'h11111111; in_sub = 1'b0; in_cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready_low", 64'(in_ready), 64'(0));
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_in_ready", 64'(in_ready), 64'(0));
    chk("midrst_outs", 64'({out_cout, out_ovf, out_result}), 64'(0));
    repeat (4) @(negedge clk);
    chk("midrst_no_partial", 64'(out_valid), 64'(0));
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_release_ready", 64'(in_ready), 64'(1));
    op32(32'h1234, 32'h1111, 1'b0, 1'b0, res, cout, ovf, lat);
    chk("midrst_fresh_result", 64'(res), 64'(32'h2345));
    chk("midrst_fresh_latency", 64'(lat), 64'(4));

    // 16-bit instances: CHUNK=WIDTH and CHUNK=4
    op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, o1, o2, lat1, lat2);
    chk("w16c16_result", 64'(o1), 64'(17'h10000));
    chk("w16c4_result", 64'(o2), 64'(17'h10000));
    chk("w16c16_latency", 64'(lat1), 64'(1));
    chk("w16c4_latency", 64'(lat2), 64'(4));
    chk("w16_ovf", 64'({r1_ovf, r2_ovf}), 64'(0));
    for (int i = 0; i < 6; i++) begin
      m16 = model16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      s_a = 16'($urandom); s_b = 16'($urandom); rs = 1'($urandom); rc = 1'($urandom);
      m16 = model16(s_a, s_b, rs, rc);
      op16(s_a, s_b, rs, rc, o1, o2, lat1, lat2);
      chk($sformatf("rnd%0d_w16c16", i), 64'({r1_ovf, o1}), 64'(m16));
      chk($sformatf("rnd%0d_w16c4", i), 64'({r2_ovf, o2}), 64'(m16));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
